mul_mod_p: RTL and testbench
============================

// Module: mul_mod_p
// PURPOSE
//   Sequential field multiplier over GF(p), p = 2^255-19 (Blakley interleaved shift-add-reduce).
//   Computes result = (a*b) mod p one multiplier bit per clock, MSB first, using 2 conditional subtracts.
//   Sits directly downstream of mod_p: its operands are the canonical (< p) remainders mod_p produces.
//   Start/done handshake; result held stable until the next accepted start.
// PARAMETERS
//   N   256                     operand/result width in bits
//   P   2^255-19 (N bits)       field modulus; must satisfy 2^(N-1) <= P < 2^N
// PORTS
//   clk     in   1   clock; all state updates on rising edge
//   rst_n   in   1   asynchronous, active-low reset
//   start   in   1   request; sampled only in IDLE
//   a       in   N   multiplicand, must be < P; latched when start is accepted
//   b       in   N   multiplier, must be < P; latched when start is accepted
//   busy    out  1   high while an operation is in flight
//   done    out  1   one-cycle pulse: result is valid
//   result  out  N   (a*b) mod P; held until next done
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0; acc, cnt, operand regs cleared.
//     Reset mid-operation aborts it; no done is produced for the aborted operation.
//   States: IDLE -> RUN -> IDLE (done pulsed on the RUN exit edge).
//   IDLE: done cleared each cycle. On edge E0 with start=1: latch a_r=a, b_r=b, acc=0, cnt=N-1, busy=1 -> RUN.
//   RUN (edges E1..EN): t = 2*acc + (b_r[cnt] ? a_r : 0), computed N+2 bits wide (t < 3P < 2^(N+2)).
//     if t >= 2P: acc = t-2P; else if t >= P: acc = t-P; else acc = t. Post-step acc < P always.
//     cnt decrements; on the edge processing cnt==0 (EN): result=final acc, done=1, busy=0 -> IDLE.
//   Latency: done high in the cycle after EN, i.e. N clock edges after the start-sampling edge E0.
//   done is high for exactly one cycle. busy and done are never high together.
//   start while busy: ignored, operands not re-latched. start held high continuously: a new op is
//     accepted on the first IDLE edge after done (back-to-back throughput = N+1 cycles/op).
//   start coincident with done edge: not accepted (state is still RUN on that edge).
//   a or b >= P: out of contract; result is unspecified but still < 2^N, timing unchanged.
//   result never changes except on the done edge or reset.
// CONFIGURATION
//   MUL_MOD_P_EARLY_EXIT_EN
//     defined:   on accepted start with a==0 or b==0, skip RUN: next edge (E1) sets result=0,
//                done=1, busy=0. Latency 1 cycle. Nonzero operands unchanged (N cycles).
//     undefined: all operations take N cycles regardless of operand values; zero operands give 0.
// TESTING
//   Clock 20 ns period; release rst_n after reset; check busy/done/result on every edge.
//   1. a=7_000_000, b=1 -> result=7_000_000, done exactly 256 edges after start edge.
//   2. a=p-1, b=p-1 -> result=1; a=2, b=2^254-9 ((p+1)/2) -> result=1.
//   3. a=2^128, b=2^128 -> result=38 (2^256 mod p); a=0xdeadbeef, b=0x100000000
//      -> result=0xdeadbeef00000000.
//   4. start pulsed at cycles 5 and 100 of an op -> ignored, single done with first op's result;
//      start held high -> second op accepted on edge after done, done spacing 257 cycles.
//   5. rst_n=0 at cycle 128 of an op -> busy=0, done=0, result=0 immediately (async);
//      no done; next op a=3, b=5 -> result=15.
//   6. a=0, b=12345: with MUL_MOD_P_EARLY_EXIT_EN done 1 cycle after start, else 256; result=0.
//   Reference model: bench computes (a*b) % p with 512-bit arithmetic; compare every done.

Source files
------------

// File: rtl/mul_mod_p_if.sv
// Start/done handshake bundle for mul_mod_p: the requester drives start/a/b and the multiplier drives busy/done/result.
interface mul_mod_p_if #(
  parameter int N = 256
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  modport master (output start, a, b, input busy, done, result);
  modport slave  (input start, a, b, output busy, done, result);
endinterface

// File: rtl/mul_mod_p.sv
// Blakley multiplier mod P, one multiplier bit per clock (MSB first): N cycles, start ignored while busy.
// MUL_MOD_P_EARLY_EXIT_EN finishes zero-operand products in one cycle.
module mul_mod_p #(
  parameter int           N = 256,
  parameter logic [N-1:0] P = (N'(1) << (N - 1)) - N'(19)
) (
  input  logic        clk,
  input  logic        rst_n,
  mul_mod_p_if.slave  bus
);
  localparam int CW = $clog2(N);
  localparam logic [N+1:0] P1 = {2'b00, P};
  localparam logic [N+1:0] P2 = {1'b0, P, 1'b0};

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  a_r, a_nxt, b_r, b_nxt, acc, acc_nxt, result, result_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          busy, busy_nxt, done, done_nxt;
  logic [N+1:0]  t, red;
  logic          unused_red_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      a_r    <= a_nxt;
      b_r    <= b_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      result <= result_nxt;
    end
  end

  // t < 3P, so at most two subtractions bring it back below P.
  always_comb begin
    t = {1'b0, acc, 1'b0} + {2'b00, (b_r[cnt] ? a_r : '0)};
    if (t >= P2)      red = t - P2;
    else if (t >= P1) red = t - P1;
    else              red = t;
  end

  assign unused_red_hi = ^red[N+1:N];

  always_comb begin
    state_nxt  = state;
    a_nxt      = a_r;
    b_nxt      = b_r;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    result_nxt = result;
    case (state)
      IDLE: begin
        if (bus.start) begin
          a_nxt     = bus.a;
          b_nxt     = bus.b;
          acc_nxt   = '0;
          cnt_nxt   = CW'(N - 1);
`ifdef MUL_MOD_P_EARLY_EXIT_EN
          // A single step on bit 0 of a zero operand yields 0.
          if (bus.a == '0 || bus.b == '0) cnt_nxt = '0;
`endif
          busy_nxt  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        acc_nxt = red[N-1:0];
        cnt_nxt = cnt - CW'(1);
        if (cnt == '0) begin
          result_nxt = red[N-1:0];
          done_nxt   = 1'b1;
          busy_nxt   = 1'b0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result;
endmodule

// File: tb/tb_mul_mod_p.sv
// Directed bench for mul_mod_p: hand-computed products mod 2^255-19, latency, start filtering and async reset.
module tb_mul_mod_p;
  localparam int N = 256;
  localparam logic [N-1:0] P = (N'(1) << 255) - N'(19);
`ifdef MUL_MOD_P_EARLY_EXIT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 256;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  mul_mod_p_if #(.N(N)) bus ();
  mul_mod_p #(.N(N), .P(P)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #10 clk = ~clk;

  function automatic logic [N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [2*N-1:0] pr;
    logic [2*N-1:0] rm;
    pr = {{N{1'b0}}, x} * {{N{1'b0}}, y};
    rm = pr % {{N{1'b0}}, P};
    return rm[N-1:0];
  endfunction

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one op and follows it to done, checking timing, invariants and result.
  task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic [N-1:0] ex,
                       input int lat_exp, input string tag);
    int lat;
    bit seen;
    bit ok;
    logic [N-1:0] prev;
    @(negedge clk);
    bus.start = 1'b1; bus.a = ta; bus.b = tb;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_busy"}, N'(bus.busy), N'(1));
    lat = 0; seen = 1'b0; ok = 1'b1; prev = bus.result;
    while (!seen && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) seen = 1'b1;
      else if (!bus.busy || bus.result !== prev) ok = 1'b0;
      if (bus.busy && bus.done) ok = 1'b0;
    end
    check({tag, "_seen"}, N'(seen), N'(1));
    check({tag, "_lat"}, N'(lat), N'(lat_exp));
    check({tag, "_res"}, bus.result, ex);
    check({tag, "_model"}, bus.result, ref_mul(ta, tb));
    check({tag, "_inv"}, N'(ok), N'(1));
    @(posedge clk); #1;
    check({tag, "_pulse"}, N'(bus.done), N'(0));
    check({tag, "_hold"}, bus.result, ex);
  endtask

  initial begin
    int lat, d1, d2, ndone;
    bit seen;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", N'(bus.busy), N'(0));
    check("rst_done", N'(bus.done), N'(0));
    check("rst_result", bus.result, '0);
    @(negedge clk); rst_n = 1'b1;

    do_op(N'(7000000), N'(1), N'(7000000), 256, "t1");
    do_op(P - N'(1), P - N'(1), N'(1), 256, "t2a");
    do_op(N'(2), (N'(1) << 254) - N'(9), N'(1), 256, "t2b");
    do_op(N'(1) << 128, N'(1) << 128, N'(38), 256, "t3a");
    do_op(N'(64'hdeadbeef), N'(64'h100000000), N'(64'hdeadbeef00000000), 256, "t3b");

    // start pulses mid-operation must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = N'(36'h123456789); bus.b = N'(16'h1000);
    @(posedge clk); #1;
    bus.start = 1'b0;
    seen = 1'b0; lat = 0;
    for (int c = 1; c <= 400 && !seen; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin seen = 1'b1; lat = c; end
      if (c == 5 || c == 100) begin bus.start = 1'b1; bus.a = P - N'(1); bus.b = P - N'(2); end
      else bus.start = 1'b0;
    end
    check("t4_lat", N'(lat), N'(256));
    check("t4_res", bus.result, N'(48'h123456789000));
    ndone = 0;
    repeat (20) begin @(posedge clk); #1; if (bus.done) ndone++; end
    check("t4_single_done", N'(ndone), N'(0));

    // start held high: back-to-back ops, new operands presented after the first done
    @(negedge clk);
    bus.start = 1'b1; bus.a = N'(7); bus.b = N'(9);
    @(posedge clk); #1;
    d1 = 0; d2 = 0;
    for (int c = 1; c <= 700 && d2 == 0; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        if (d1 == 0) begin
          d1 = c;
          check("t4_b2b_res1", bus.result, N'(63));
          bus.a = P - N'(1); bus.b = N'(2);
        end else begin
          d2 = c;
          bus.start = 1'b0;
          check("t4_b2b_res2", bus.result, P - N'(2));
        end
      end
    end
    check("t4_b2b_first", N'(d1), N'(256));
    check("t4_b2b_spacing", N'(d2 - d1), N'(257));
    repeat (2) @(posedge clk);

    // asynchronous reset mid-operation
    @(negedge clk);
    bus.start = 1'b1; bus.a = N'(12'habc); bus.b = N'(16);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (128) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_busy", N'(bus.busy), N'(0));
    check("t5_done", N'(bus.done), N'(0));
    check("t5_result", bus.result, '0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (300) begin @(posedge clk); #1; if (bus.done || bus.busy) ndone++; end
    check("t5_no_done", N'(ndone), N'(0));
    do_op(N'(3), N'(5), N'(15), 256, "t5_next");

    do_op(N'(0), N'(12345), N'(0), ZLAT, "t6_zero");
    do_op(N'(12345), N'(0), N'(0), ZLAT, "t6_zero_b");
    do_op(N'(11), N'(13), N'(143), 256, "t6_nonzero");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
